// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller: FSM states,
// coin values in 5-cent units and the coin-hold encoding.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VEND   = 2'd1,
        CHANGE = 2'd2
    } state_e;

    localparam int NICKEL  = 1;
    localparam int DIME    = 2;
    localparam int QUARTER = 5;

    typedef enum logic [1:0] {
        HOLD_NONE    = 2'd0,
        HOLD_NICKEL  = 2'd1,
        HOLD_DIME    = 2'd2,
        HOLD_QUARTER = 2'd3
    } hold_e;

    function automatic logic [2:0] hold_units(hold_e h);
        case (h)
            HOLD_NICKEL:  return 3'(NICKEL);
            HOLD_DIME:    return 3'(DIME);
            HOLD_QUARTER: return 3'(QUARTER);
            default:      return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/vend_coin_latch.sv
// Coin capture: the first coin level seen is held until all sensors go low,
// then a one-cycle release strobe is raised together with the coin value.
module vend_coin_latch
    import vend_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       nickel_i,
    input  logic       dime_i,
    input  logic       quarter_i,
    output logic       rel_o,
    output logic [2:0] units_o
);

    hold_e hold_q, hold_d;
    logic  any_coin;

    assign any_coin = nickel_i | dime_i | quarter_i;

    always_comb begin
        hold_d = hold_q;
        if (hold_q == HOLD_NONE) begin
            // Simultaneous levels resolve to the most valuable coin.
            if (quarter_i)     hold_d = HOLD_QUARTER;
            else if (dime_i)   hold_d = HOLD_DIME;
            else if (nickel_i) hold_d = HOLD_NICKEL;
        end else if (!any_coin) begin
            hold_d = HOLD_NONE;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) hold_q <= HOLD_NONE;
        else     hold_q <= hold_d;
    end

    assign rel_o   = (hold_q != HOLD_NONE) && !any_coin;
    assign units_o = hold_units(hold_q);

endmodule

// File: rtl/vend_ctrl.sv
// Vending controller: accumulates coin credit, vends at PRICE_UNITS and
// pays back change as dimes then a nickel through a handshaked hopper.
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int PRICE_UNITS = 5,
    parameter int CREDIT_W    = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                nickel,
    input  logic                dime,
    input  logic                quarter,
    input  logic                cancel,
    input  logic                chg_ack,
    output logic [CREDIT_W-1:0] credit,
    output logic                dispense,
    output logic                chg_valid,
    output logic                chg_coin,
    output logic                coin_reject,
    output logic                busy
);

    if ((2 ** CREDIT_W) - 1 < PRICE_UNITS + 4) begin : g_bad_credit_w
        $error("vend_ctrl: CREDIT_W too narrow for PRICE_UNITS+4");
    end
    if (PRICE_UNITS < 1 || PRICE_UNITS > 30) begin : g_bad_price
        $error("vend_ctrl: PRICE_UNITS out of range 1..30");
    end

    logic       rel;
    logic [2:0] rel_units;

    vend_coin_latch u_latch (
        .CLK      (CLK),
        .RST      (RST),
        .nickel_i (nickel),
        .dime_i   (dime),
        .quarter_i(quarter),
        .rel_o    (rel),
        .units_o  (rel_units)
    );

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                dispense_q, dispense_d;
    logic                chg_valid_q, chg_valid_d;
    logic                chg_coin_q, chg_coin_d;
    logic                coin_reject_q, coin_reject_d;
    logic                busy_q, busy_d;
    logic [CREDIT_W:0]   sum;

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        sum      = {1'b0, credit_q} + (CREDIT_W+1)'(rel_units);
        case (state_q)
            IDLE: begin
                // A release wins over cancel in the same cycle.
                if (rel) begin
                    if (sum >= (CREDIT_W+1)'(PRICE_UNITS)) begin
                        state_d  = VEND;
                        credit_d = CREDIT_W'(sum - (CREDIT_W+1)'(PRICE_UNITS));
                    end else begin
                        credit_d = sum[CREDIT_W-1:0];
                    end
                end else if (cancel && credit_q != '0) begin
                    state_d = CHANGE;
                end
            end
            VEND: state_d = (credit_q != '0) ? CHANGE : IDLE;
            CHANGE: begin
                if (chg_valid_q && chg_ack) begin
                    credit_d = credit_q - CREDIT_W'(chg_coin_q ? DIME : NICKEL);
                    if (credit_d == '0) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they register in step with it.
        dispense_d    = (state_d == VEND);
        chg_valid_d   = (state_d == CHANGE);
        chg_coin_d    = (state_d == CHANGE) && (credit_d >= CREDIT_W'(DIME));
        coin_reject_d = rel && (state_q != IDLE);
        busy_d        = (state_d != IDLE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q       <= IDLE;
            credit_q      <= '0;
            dispense_q    <= 1'b0;
            chg_valid_q   <= 1'b0;
            chg_coin_q    <= 1'b0;
            coin_reject_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            dispense_q    <= dispense_d;
            chg_valid_q   <= chg_valid_d;
            chg_coin_q    <= chg_coin_d;
            coin_reject_q <= coin_reject_d;
            busy_q        <= busy_d;
        end
    end

    assign credit      = credit_q;
    assign dispense    = dispense_q;
    assign chg_valid   = chg_valid_q;
    assign chg_coin    = chg_coin_q;
    assign coin_reject = coin_reject_q;
    assign busy        = busy_q;

endmodule
